// File: rtl/gba_fb_scanout_if.sv
// Framebuffer read port plus video output pins of the scan-out generator.
// Latency: rd_data is expected one clock after rd_addr; video pins are registered.
// Backpressure: none, the video side is a free-running sink.
interface gba_fb_scanout_if #(
    parameter int PIX_W  = 15,
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              ce_pix;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;
    logic              hs;
    logic              vs;
    logic              hbl;
    logic              vbl;
    logic              de;

    // Scan-out generator side
    modport master (
        output rd_addr, ce_pix, r, g, b, hs, vs, hbl, vbl, de,
        input  rd_data
    );

    // RAM / display side
    modport slave (
        input  rd_addr, ce_pix, r, g, b, hs, vs, hbl, vbl, de,
        output rd_data
    );
endinterface

// File: rtl/gba_fb_scanout.sv
// Framebuffer scan-out timing generator: parametrised raster, free-run or frame-locked.
// Latency: pixel word fetched at rd_addr appears on r/g/b at the next pixel tick.
// Backpressure: none; in frame-locked mode the raster holds in WAIT until frame_done.
module gba_fb_scanout #(
    parameter int H_ACTIVE   = 240,
    parameter int H_TOTAL    = 256,
    parameter int HS_START   = 244,
    parameter int HS_END     = 252,
    parameter int V_ACTIVE   = 160,
    parameter int V_TOTAL    = 228,
    parameter int VS_START   = 163,
    parameter int VS_END     = 166,
    parameter int CE_DIV     = 4,
    parameter int PIX_W      = 15,
    parameter int ADDR_W     = 17,
    parameter int DOUBLE_BUF = 0
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             lock_mode,
    input  logic             frame_done,
    output logic             buf_sel,
    output logic             waiting,
    output logic             frame_skip,
    gba_fb_scanout_if.master vid
);
    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);
    localparam int DW = $clog2(CE_DIV);

    localparam logic [XW-1:0]     X_ACT      = XW'(H_ACTIVE);
    localparam logic [XW-1:0]     X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0]     X_HS_START = XW'(HS_START);
    localparam logic [XW-1:0]     X_HS_END   = XW'(HS_END);
    localparam logic [YW-1:0]     Y_ACT      = YW'(V_ACTIVE);
    localparam logic [YW-1:0]     Y_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0]     Y_VS_START = YW'(VS_START);
    localparam logic [YW-1:0]     Y_VS_END   = YW'(VS_END);
    localparam logic [DW-1:0]     DIV_LAST   = DW'(CE_DIV - 1);
    localparam logic [ADDR_W-1:0] FRAME_PIX  = ADDR_W'(H_ACTIVE * V_ACTIVE);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            st;
    logic [DW-1:0]     div;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] lin;
    logic              pending;

    logic              ce_q;
    logic              hs_q;
    logic              vs_q;
    logic              hbl_q;
    logic              vbl_q;
    logic              de_q;
    logic [7:0]        r_q;
    logic [7:0]        g_q;
    logic [7:0]        b_q;

    logic              tick;
    logic              at_last;
    logic              vis;
    logic              restart;
    logic              go_wait;
    logic [ADDR_W-1:0] buf_base;
    logic [4:0]        c_r;
    logic [4:0]        c_g;
    logic [4:0]        c_b;

    assign tick    = (div == '0);
    assign at_last = (x == X_LAST) && (y == Y_LAST);
    assign vis     = (x < X_ACT) && (y < Y_ACT);
    // A restart happens at end of frame in RUN, or on any tick in WAIT, unless
    // frame-locked and the writer has not yet delivered a new frame.
    assign restart = tick && ((st == ST_WAIT) || at_last) && (!lock_mode || pending);
    assign go_wait = tick && (st == ST_RUN) && at_last && !restart;

    assign buf_base = ((DOUBLE_BUF != 0) && buf_sel) ? FRAME_PIX : '0;

    assign c_r = vid.rd_data[PIX_W-1  -: 5];
    assign c_g = vid.rd_data[PIX_W-6  -: 5];
    assign c_b = vid.rd_data[PIX_W-11 -: 5];

    assign vid.rd_addr = buf_base + lin;
    assign vid.ce_pix  = ce_q;
    assign vid.r       = r_q;
    assign vid.g       = g_q;
    assign vid.b       = b_q;
    assign vid.hs      = hs_q;
    assign vid.vs      = vs_q;
    assign vid.hbl     = hbl_q;
    assign vid.vbl     = vbl_q;
    assign vid.de      = de_q;

    // Raster state machine, pixel divider, frame handshake and registered video outputs
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            st         <= ST_WAIT;
            div        <= '0;
            x          <= '0;
            y          <= '0;
            lin        <= '0;
            pending    <= 1'b0;
            buf_sel    <= 1'b0;
            waiting    <= 1'b0;
            frame_skip <= 1'b0;
            ce_q       <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            hbl_q      <= 1'b0;
            vbl_q      <= 1'b0;
            de_q       <= 1'b0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;

            // ce_pix marks the clock after a tick that actually advanced the raster
            ce_q <= tick && (st == ST_RUN);

            // A restart consumes the pending frame; a coincident frame_done re-queues one
            pending    <= (pending && !restart) || frame_done;
            frame_skip <= frame_done && pending && !restart;

            if ((DOUBLE_BUF != 0) && restart && pending) begin
                buf_sel <= ~buf_sel;
            end

            waiting <= go_wait || ((st == ST_WAIT) && !restart);

            if (tick) begin
                case (st)
                    ST_RUN: begin
                        r_q   <= vis ? {c_r, c_r[4:2]} : 8'd0;
                        g_q   <= vis ? {c_g, c_g[4:2]} : 8'd0;
                        b_q   <= vis ? {c_b, c_b[4:2]} : 8'd0;
                        hbl_q <= (x >= X_ACT);
                        vbl_q <= (y >= Y_ACT);
                        de_q  <= vis;

                        if (x == X_HS_START) begin
                            hs_q <= 1'b1;
                            if (y == Y_VS_START) begin
                                vs_q <= 1'b1;
                            end else if (y == Y_VS_END) begin
                                vs_q <= 1'b0;
                            end
                        end
                        if (x == X_HS_END) begin
                            hs_q <= 1'b0;
                        end

                        // Advance the read pointer as soon as a visible word is used,
                        // so the next word is ready by the next tick.
                        if (vis) begin
                            lin <= lin + 1'b1;
                        end

                        if (at_last) begin
                            if (restart) begin
                                x   <= '0;
                                y   <= '0;
                                lin <= '0;
                            end else begin
                                st    <= ST_WAIT;
                                hbl_q <= 1'b1;
                                vbl_q <= 1'b1;
                                hs_q  <= 1'b0;
                                vs_q  <= 1'b0;
                                de_q  <= 1'b0;
                            end
                        end else if (x == X_LAST) begin
                            x <= '0;
                            y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                    default: begin
                        if (restart) begin
                            st  <= ST_RUN;
                            x   <= '0;
                            y   <= '0;
                            lin <= '0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gba_fb_scanout.sv
// Testbench for gba_fb_scanout on a reduced raster with a random-content framebuffer.
// Latency: expected pixels come from raster arithmetic, checked on each ce_pix.
// Backpressure: not applicable; frame_done pulses are driven by the bench.
module tb_gba_fb_scanout;
    localparam int HA  = 12;
    localparam int HT  = 20;
    localparam int HSS = 14;
    localparam int HSE = 17;
    localparam int VA  = 6;
    localparam int VT  = 10;
    localparam int VSS = 7;
    localparam int VSE = 8;
    localparam int FP  = HA * VA;
    localparam int NT  = HT * VT;
    localparam int CE1 = 4;
    localparam int CE2 = 3;

    typedef struct packed {
        logic       de;
        logic       hbl;
        logic       vbl;
        logic       hs;
        logic       vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vid_t;

    logic clk;
    logic reset;
    logic lock_mode;
    logic frame_done;
    logic buf_sel1, waiting1, skip1;
    logic buf_sel2, waiting2, skip2;

    int n_cmp;
    int n_fail;
    int skip_cnt;
    bit sel;

    gba_fb_scanout_if #(.PIX_W(15), .ADDR_W(17)) bus1 ();
    gba_fb_scanout_if #(.PIX_W(15), .ADDR_W(17)) bus2 ();

    gba_fb_scanout #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HSS), .HS_END(HSE),
        .V_ACTIVE(VA), .V_TOTAL(VT), .VS_START(VSS), .VS_END(VSE),
        .CE_DIV(CE1), .PIX_W(15), .ADDR_W(17), .DOUBLE_BUF(0)
    ) dut1 (
        .clk_sys(clk), .reset(reset), .lock_mode(lock_mode), .frame_done(frame_done),
        .buf_sel(buf_sel1), .waiting(waiting1), .frame_skip(skip1), .vid(bus1)
    );

    gba_fb_scanout #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HSS), .HS_END(HSE),
        .V_ACTIVE(VA), .V_TOTAL(VT), .VS_START(VSS), .VS_END(VSE),
        .CE_DIV(CE2), .PIX_W(15), .ADDR_W(17), .DOUBLE_BUF(1)
    ) dut2 (
        .clk_sys(clk), .reset(reset), .lock_mode(lock_mode), .frame_done(frame_done),
        .buf_sel(buf_sel2), .waiting(waiting2), .frame_skip(skip2), .vid(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer with random contents; both buffers plus one guard word
    logic [14:0] ram [0:2*FP];

    function automatic logic [14:0] ram_rd(input logic [16:0] a);
        int idx;
        idx = int'(a);
        if (idx <= 2 * FP) return ram[idx];
        return 15'd0;
    endfunction

    always @(posedge clk) begin
        bus1.rd_data <= ram_rd(bus1.rd_addr);
        bus2.rd_data <= ram_rd(bus2.rd_addr);
    end

    // Observation mux: sel picks which DUT the scenario looks at
    vid_t        ovid;
    logic        oce, obuf, owait, oskip;
    logic [16:0] oaddr;
    always_comb begin
        if (sel) begin
            ovid  = {bus2.de, bus2.hbl, bus2.vbl, bus2.hs, bus2.vs, bus2.r, bus2.g, bus2.b};
            oce   = bus2.ce_pix;
            oaddr = bus2.rd_addr;
            obuf  = buf_sel2;
            owait = waiting2;
            oskip = skip2;
        end else begin
            ovid  = {bus1.de, bus1.hbl, bus1.vbl, bus1.hs, bus1.vs, bus1.r, bus1.g, bus1.b};
            oce   = bus1.ce_pix;
            oaddr = bus1.rd_addr;
            obuf  = buf_sel1;
            owait = waiting1;
            oskip = skip1;
        end
    end

    initial skip_cnt = 0;
    always @(negedge clk) begin
        if (oskip === 1'b1) skip_cnt <= skip_cnt + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] c58(input int c);
        return 8'((c << 3) | (c >> 2));
    endfunction

    // Video state right after the raster tick at linear position p of a frame
    function automatic vid_t exp_pix(input int p, input int base);
        vid_t v;
        int x, y, w;
        x = p % HT;
        y = p / HT;
        v.de  = (x < HA) && (y < VA);
        v.hbl = (x >= HA);
        v.vbl = (y >= VA);
        v.hs  = (x >= HSS) && (x < HSE);
        v.vs  = (p >= VSS * HT + HSS) && (p < VSE * HT + HSS);
        if (v.de) begin
            w   = int'(ram[base + y * HA + x]);
            v.r = c58((w >> 10) & 31);
            v.g = c58((w >> 5) & 31);
            v.b = c58(w & 31);
        end else begin
            v.r = 8'd0;
            v.g = 8'd0;
            v.b = 8'd0;
        end
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic pulse_fd();
        frame_done = 1'b1;
        fork
            begin
                @(negedge clk);
                frame_done = 1'b0;
            end
        join_none
    endtask

    task automatic do_reset(input bit lk);
        reset      = 1'b1;
        lock_mode  = lk;
        frame_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic next_ce(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (oce !== 1'b1 && n < 100);
        if (oce !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ce_timeout: no ce_pix within %0d clocks", n);
        end
    endtask

    // Walks np pixel ticks of one frame, checking every ce_pix against the model
    task automatic scan_frame(input int base, input int nbase, input bit restart,
                              input bit first, input bit fd_pre, input int lock_at,
                              input int fd_a, input int fd_b, input bit fd_coinc,
                              input int np, output int n0);
        int   n, pre, cd, ea, x, y;
        vid_t e;
        cd = sel ? CE2 : CE1;
        n0 = 0;
        if (fd_pre) pulse_fd();
        for (int p = 0; p < np; p++) begin
            pre = 0;
            if (fd_coinc && p == NT - 1) begin
                repeat (cd - 1) @(negedge clk);
                pre = cd - 1;
                pulse_fd();
            end
            next_ce(n);
            n += pre;
            if (p == 0) n0 = n;
            if (!(first && p == 0)) begin
                n_cmp++;
                if (n !== cd) begin
                    n_fail++;
                    $display("FAIL ce_period p=%0d: got %0d clocks, want %0d", p, n, cd);
                end
            end
            e = exp_pix(p, base);
            n_cmp++;
            if (ovid !== e) begin
                n_fail++;
                $display("FAIL video p=%0d: got %h, want %h", p, ovid, e);
            end
            x = p % HT;
            y = p / HT;
            if (p == NT - 1) ea = restart ? nbase : base + FP;
            else if (y >= VA) ea = base + FP;
            else ea = base + y * HA + ((x < HA) ? x + 1 : HA);
            n_cmp++;
            if (oaddr !== 17'(ea)) begin
                n_fail++;
                $display("FAIL rd_addr p=%0d: got %0d, want %0d", p, oaddr, ea);
            end
            if (p == 0) begin
                n_cmp++;
                if (obuf !== (base != 0)) begin
                    n_fail++;
                    $display("FAIL buf_sel: got %b, want %b", obuf, (base != 0));
                end
                n_cmp++;
                if (owait !== 1'b0) begin
                    n_fail++;
                    $display("FAIL waiting_run: got %b, want 0", owait);
                end
            end
            if (p == lock_at) lock_mode = 1'b1;
            if (p == fd_a || p == fd_b) pulse_fd();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset      = 1'b1;
        lock_mode  = 1'b0;
        frame_done = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_cmp++;
            if (oce !== 1'b0) begin n_fail++; $display("FAIL reset_ce dut%0d: got %b, want 0", s, oce); end
            n_cmp++;
            if (ovid !== '0) begin n_fail++; $display("FAIL reset_video dut%0d: got %h, want 0", s, ovid); end
            n_cmp++;
            if (oaddr !== '0) begin n_fail++; $display("FAIL reset_addr dut%0d: got %0d, want 0", s, oaddr); end
            n_cmp++;
            if (obuf !== 1'b0) begin n_fail++; $display("FAIL reset_buf dut%0d: got %b, want 0", s, obuf); end
            n_cmp++;
            if (owait !== 1'b0) begin n_fail++; $display("FAIL reset_wait dut%0d: got %b, want 0", s, owait); end
            n_cmp++;
            if (oskip !== 1'b0) begin n_fail++; $display("FAIL reset_skip dut%0d: got %b, want 0", s, oskip); end
        end
    endtask

    task automatic test_free_run();
        int n0;
        sel = 1'b0;
        do_reset(1'b0);
        scan_frame(0, 0, 1'b1, 1'b1, 1'b0, -1, -1, -1, 1'b0, NT, n0);
        scan_frame(0, 0, 1'b1, 1'b0, 1'b0, -1, $urandom_range(1, NT - 3), -1, 1'b0, NT, n0);
    endtask

    task automatic test_lock_wait();
        int n0, ce_seen;
        sel = 1'b0;
        do_reset(1'b0);
        scan_frame(0, 0, 1'b0, 1'b1, 1'b0, $urandom_range(1, NT - 3), -1, -1, 1'b0, NT, n0);
        ce_seen = 0;
        repeat (5 * CE1) begin
            @(negedge clk);
            if (oce === 1'b1) ce_seen++;
        end
        n_cmp++;
        if (ce_seen !== 0) begin n_fail++; $display("FAIL wait_ce: got %0d pulses, want 0", ce_seen); end
        n_cmp++;
        if (owait !== 1'b1) begin n_fail++; $display("FAIL wait_flag: got %b, want 1", owait); end
        n_cmp++;
        if (ovid !== vid_t'({5'b01100, 24'd0})) begin
            n_fail++;
            $display("FAIL wait_video: got %h, want %h", ovid, vid_t'({5'b01100, 24'd0}));
        end
        scan_frame(0, 0, 1'b0, 1'b1, 1'b1, -1, -1, -1, 1'b0, NT, n0);
        n_cmp++;
        if (n0 < CE1 + 2 || n0 > 2 * CE1 + 1) begin
            n_fail++;
            $display("FAIL wait_exit_latency: got %0d clocks, want %0d..%0d", n0, CE1 + 2, 2 * CE1 + 1);
        end
        n_cmp++;
        if (owait !== 1'b1) begin n_fail++; $display("FAIL wait_again: got %b, want 1", owait); end
    endtask

    task automatic test_frame_skip();
        int n0, s0;
        sel = 1'b0;
        s0 = skip_cnt;
        scan_frame(0, 0, 1'b1, 1'b1, 1'b1, -1, $urandom_range(2, 90),
                   $urandom_range(100, NT - 3), 1'b0, NT, n0);
        n_cmp++;
        if (skip_cnt - s0 !== 1) begin
            n_fail++;
            $display("FAIL skip_count: got %0d, want 1", skip_cnt - s0);
        end
        scan_frame(0, 0, 1'b0, 1'b0, 1'b0, -1, -1, -1, 1'b0, NT, n0);
        n_cmp++;
        if (owait !== 1'b1) begin n_fail++; $display("FAIL skip_one_restart: got %b, want 1", owait); end
    endtask

    task automatic test_double_buf();
        int n0, s0;
        sel = 1'b1;
        do_reset(1'b0);
        s0 = skip_cnt;
        scan_frame(0,  FP, 1'b1, 1'b1, 1'b0, 2,  $urandom_range(5, NT - 3), -1, 1'b0, NT, n0);
        scan_frame(FP, 0,  1'b1, 1'b0, 1'b0, -1, $urandom_range(1, NT - 3), -1, 1'b0, NT, n0);
        scan_frame(0,  FP, 1'b1, 1'b0, 1'b0, -1, $urandom_range(1, NT - 3), -1, 1'b1, NT, n0);
        scan_frame(FP, 0,  1'b1, 1'b0, 1'b0, -1, -1, -1, 1'b0, NT, n0);
        scan_frame(0,  0,  1'b0, 1'b0, 1'b0, -1, -1, -1, 1'b0, NT, n0);
        n_cmp++;
        if (skip_cnt - s0 !== 0) begin
            n_fail++;
            $display("FAIL db_skip_count: got %0d, want 0", skip_cnt - s0);
        end
        n_cmp++;
        if (owait !== 1'b1) begin n_fail++; $display("FAIL db_wait: got %b, want 1", owait); end
        n_cmp++;
        if (obuf !== 1'b0) begin n_fail++; $display("FAIL db_final_buf: got %b, want 0", obuf); end
    endtask

    task automatic test_reset_mid();
        int n0;
        sel = 1'b0;
        do_reset(1'b0);
        scan_frame(0, 0, 1'b1, 1'b1, 1'b0, -1, -1, -1, 1'b0, 2 * HT + 8, n0);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (oce !== 1'b0) begin n_fail++; $display("FAIL midreset_ce: got %b, want 0", oce); end
        n_cmp++;
        if (ovid !== '0) begin n_fail++; $display("FAIL midreset_video: got %h, want 0", ovid); end
        n_cmp++;
        if (oaddr !== '0) begin n_fail++; $display("FAIL midreset_addr: got %0d, want 0", oaddr); end
        n_cmp++;
        if (owait !== 1'b0) begin n_fail++; $display("FAIL midreset_wait: got %b, want 0", owait); end
        @(negedge clk);
        reset = 1'b0;
        scan_frame(0, 0, 1'b1, 1'b1, 1'b0, -1, -1, -1, 1'b0, NT, n0);
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        sel        = 1'b0;
        reset      = 1'b1;
        lock_mode  = 1'b0;
        frame_done = 1'b0;
        for (int i = 0; i <= 2 * FP; i++) ram[i] = 15'($urandom);
        test_reset();
        test_free_run();
        test_lock_wait();
        test_frame_skip();
        test_double_buf();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
